// File: rtl/ifetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface ifetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: drives the next PC and the memory request, and holds
// one output slot plus a one-entry skid buffer toward decode.
module ifetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    output logic [31:0]           pcNext,
    ifetch_stage_if.master        imem,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    input  logic                  id_ready,
    output logic                  if_valid,
    output logic [31:0]           if_instr,
    output logic [31:0]           if_pc,
    output logic                  if_misaligned
);

    typedef enum logic [1:0] {S_REQ, S_FULL, S_DROP, S_TRAP} state_t;

    state_t      state;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] drop_addr;

    logic        slot_free;
    logic        pc_misaligned;
    logic        fetch_hit;
    logic        req_c;
    logic [31:0] addr_c;
    logic [31:0] next_c;

    assign slot_free     = !if_valid || id_ready;
    assign pc_misaligned = (pc[1:0] != 2'b00);
    assign fetch_hit     = (state == S_REQ) && !pc_misaligned && imem.imem_rvalid;

    // Request and next-PC are combinational so a zero-wait memory can deliver
    // one instruction per cycle; reset forces them off without waiting for a clock.
    always_comb begin
        req_c  = 1'b0;
        addr_c = pc;
        next_c = pc;
        unique case (state)
            S_REQ: begin
                req_c = !pc_misaligned;
                if (fetch_hit)
                    next_c = pc + 32'd4;
            end
            S_DROP: begin
                req_c  = 1'b1;
                addr_c = drop_addr;
            end
            S_FULL, S_TRAP: ;
        endcase
        if (redirect)
            next_c = redirect_pc;
        if (!reset) begin
            req_c  = 1'b0;
            next_c = RESET_VECTOR;
        end
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;
    assign pcNext         = next_c;

    // The FULL state doubles as the skid-valid flag: the skid holds data exactly
    // while the FSM sits in FULL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_REQ;
            if_valid      <= 1'b0;
            if_misaligned <= 1'b0;
            if_instr      <= NOP_INSTR;
            if_pc         <= 32'd0;
            skid_instr    <= NOP_INSTR;
            skid_pc       <= 32'd0;
            drop_addr     <= 32'd0;
        end else if (redirect) begin
            if_valid      <= 1'b0;
            if_misaligned <= 1'b0;
            if_instr      <= NOP_INSTR;
            // An outstanding request must have its late response swallowed in DROP;
            // a response arriving in this very cycle closes it out instead.
            if (state == S_REQ && req_c && !imem.imem_rvalid) begin
                state     <= S_DROP;
                drop_addr <= pc;
            end else if (state == S_DROP && !imem.imem_rvalid) begin
                state <= S_DROP;
            end else begin
                state <= S_REQ;
            end
        end else begin
            if (if_valid && id_ready) begin
                if_valid      <= 1'b0;
                if_misaligned <= 1'b0;
            end
            unique case (state)
                S_REQ: begin
                    if (pc_misaligned) begin
                        if (slot_free) begin
                            if_valid      <= 1'b1;
                            if_instr      <= NOP_INSTR;
                            if_pc         <= pc;
                            if_misaligned <= 1'b1;
                            state         <= S_TRAP;
                        end
                    end else if (fetch_hit) begin
                        if (slot_free) begin
                            if_valid      <= 1'b1;
                            if_instr      <= imem.imem_rdata;
                            if_pc         <= pc;
                            if_misaligned <= 1'b0;
                        end else begin
                            skid_instr <= imem.imem_rdata;
                            skid_pc    <= pc;
                            state      <= S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (id_ready) begin
                        if_valid      <= 1'b1;
                        if_instr      <= skid_instr;
                        if_pc         <= skid_pc;
                        if_misaligned <= 1'b0;
                        state         <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.imem_rvalid)
                        state <= S_REQ;
                end
                S_TRAP: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: the bench plays the PC register and a memory
// that either answers combinationally or under manual control.
module tb_ifetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc = 32'd0;
    logic [31:0] pcNext;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_misaligned;
    logic        zw;
    logic        man_rvalid;

    int checks = 0;
    int errors = 0;

    ifetch_stage_if bus ();

    ifetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pcNext        (pcNext),
        .imem          (bus),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_misaligned (if_misaligned)
    );

    assign bus.imem_rvalid = zw ? bus.imem_req : man_rvalid;
    assign bus.imem_rdata  = {16'hC0DE, bus.imem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) pc <= pcNext;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
        zw = 1'b1; man_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_misalign", {31'd0, if_misaligned}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pcnext", pcNext, 32'd0);

        // Zero-wait streaming
        reset = 1'b1;
        @(negedge clk);
        chk("stream0_valid", {31'd0, if_valid}, 32'd1);
        chk("stream0_pc", if_pc, 32'h0);
        chk("stream0_instr", if_instr, 32'hC0DE_0000);
        @(negedge clk);
        chk("stream1_pc", if_pc, 32'h4);
        chk("stream1_valid", {31'd0, if_valid}, 32'd1);
        @(negedge clk);
        chk("stream2_pc", if_pc, 32'h8);
        @(negedge clk);
        chk("stream3_pc", if_pc, 32'hC);
        chk("stream3_valid", {31'd0, if_valid}, 32'd1);

        // Backpressure into the skid buffer
        id_ready = 1'b0;
        #1;
        chk("skid_pcnext_inc", pcNext, 32'h14);
        @(negedge clk);
        chk("full_req", {31'd0, bus.imem_req}, 32'd0);
        chk("full_if_pc", if_pc, 32'hC);
        chk("full_pcnext", pcNext, 32'h14);
        @(negedge clk);
        chk("full_pcnext_hold", pcNext, 32'h14);
        id_ready = 1'b1;
        @(negedge clk);
        chk("drain_if_pc", if_pc, 32'h10);
        chk("drain_instr", if_instr, 32'hC0DE_0010);
        chk("drain_addr", bus.imem_addr, 32'h14);
        chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
        chk("after_drain_pc", if_pc, 32'h14);

        // Redirect during an outstanding slow request
        redirect = 1'b1; redirect_pc = 32'h20;
        @(negedge clk);
        redirect = 1'b0; zw = 1'b0;
        #1;
        chk("flush_valid", {31'd0, if_valid}, 32'd0);
        chk("slow_addr0", bus.imem_addr, 32'h20);
        chk("slow_req0", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("redir_pcnext", pcNext, 32'h100);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("drop_req", {31'd0, bus.imem_req}, 32'd1);
        chk("drop_addr", bus.imem_addr, 32'h20);
        man_rvalid = 1'b1;
        @(negedge clk);
        man_rvalid = 1'b0;
        #1;
        chk("drop_discard_valid", {31'd0, if_valid}, 32'd0);
        chk("post_drop_addr", bus.imem_addr, 32'h100);
        chk("post_drop_req", {31'd0, bus.imem_req}, 32'd1);
        zw = 1'b1;
        @(negedge clk);
        chk("tgt_valid", {31'd0, if_valid}, 32'd1);
        chk("tgt_pc", if_pc, 32'h100);

        // Misaligned redirect target traps
        redirect = 1'b1; redirect_pc = 32'h102; id_ready = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("mis_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        chk("trap_valid", {31'd0, if_valid}, 32'd1);
        chk("trap_mis", {31'd0, if_misaligned}, 32'd1);
        chk("trap_instr", if_instr, 32'h0000_0013);
        chk("trap_pc", if_pc, 32'h102);
        chk("trap_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        chk("trap_hold_valid", {31'd0, if_valid}, 32'd1);
        chk("trap_hold_pcnext", pcNext, 32'h102);
        redirect = 1'b1; redirect_pc = 32'h200; id_ready = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("untrap_valid", {31'd0, if_valid}, 32'd0);
        chk("untrap_mis", {31'd0, if_misaligned}, 32'd0);
        chk("untrap_addr", bus.imem_addr, 32'h200);
        @(negedge clk);
        chk("untrap_if_pc", if_pc, 32'h200);

        // Asynchronous reset while FULL
        id_ready = 1'b0;
        @(negedge clk);
        chk("full2_req", {31'd0, bus.imem_req}, 32'd0);
        chk("full2_if_pc", if_pc, 32'h200);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_mis", {31'd0, if_misaligned}, 32'd0);
        chk("arst_instr", if_instr, 32'h0000_0013);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("arst_pcnext", pcNext, 32'd0);
        @(negedge clk);
        reset = 1'b1; id_ready = 1'b1;
        #1;
        chk("post_rst_addr", bus.imem_addr, 32'd0);
        chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        @(negedge clk);
        chk("skid_lost_pc", if_pc, 32'd0);
        chk("skid_lost_instr", if_instr, 32'hC0DE_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
IFETCH_STAGE -- requirements
Module: ifetch_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, value driven on pcNext while reset is asserted.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction word placed in if_instr on reset, flush and misaligned fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 = reset asserted.
REQ-005 pc  input  32  current PC from the PC register.
REQ-006 pcNext  output  32  next PC, loaded unconditionally by the PC register every cycle.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address; held stable while imem_req=1.
REQ-009 imem_rvalid  input  1  response valid; meaningful only while imem_req=1; may assert in the same cycle imem_req rises.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-011 redirect  input  1  branch/jump taken from execute.
REQ-012 redirect_pc  input  32  target PC, valid with redirect.
REQ-013 id_ready  input  1  decode accepts the output slot this cycle.
REQ-014 if_valid  output  1  output slot holds an instruction.
REQ-015 if_instr  output  32  fetched instruction.
REQ-016 if_pc  output  32  PC of if_instr.
REQ-017 if_misaligned  output  1  slot carries a misaligned-fetch marker instead of an instruction.

Function
REQ-018 FSM states: REQ, FULL, DROP, TRAP; slot_free = !if_valid || id_ready.
REQ-019 REQ: imem_req=1, imem_addr=pc, pcNext=pc until imem_rvalid.
REQ-020 REQ with imem_rvalid and slot_free: slot <= {1, imem_rdata, pc, 0}, pcNext=pc+4 (mod 2^32), stay REQ; one instruction per cycle with zero-wait memory.
REQ-021 REQ with imem_rvalid and !slot_free: word and pc captured in a one-entry skid buffer, pcNext=pc+4, go FULL.
REQ-022 FULL: imem_req=0, pcNext=pc; on id_ready, slot <= skid contents, skid cleared, go REQ.
REQ-023 Slot consumed (id_ready && if_valid) with no new load clears if_valid next cycle.
REQ-024 REQ with pc[1:0]!=0: imem_req=0; when slot_free, slot <= {1, NOP_INSTR, pc, 1}, go TRAP; pcNext=pc.
REQ-025 TRAP: imem_req=0, pcNext=pc; remains until redirect.
REQ-026 redirect has highest priority in every state: if_valid, if_misaligned and skid cleared next cycle, pcNext=redirect_pc, any imem_rvalid that cycle discarded.
REQ-027 redirect in REQ with imem_req=1 and imem_rvalid=0: latch imem_addr, go DROP; otherwise go REQ.
REQ-028 DROP: imem_req=1, imem_addr=latched address, pcNext=pc; first imem_rvalid discarded, go REQ next cycle.
REQ-029 redirect in DROP: pcNext=redirect_pc, stay DROP with the original latched address.
REQ-030 id_ready with if_valid=0 has no effect.

Reset
REQ-031 While reset=0: state REQ, if_valid=0, if_misaligned=0, if_instr=NOP_INSTR, if_pc=0, skid empty, imem_req=0, pcNext=RESET_VECTOR.
REQ-032 Reset assertion mid-request abandons the request immediately; first post-reset cycle starts REQ at pc.

Verification
REQ-033 Zero-wait memory, id_ready=1, pc from 0 -> if_pc 0,4,8,12 on consecutive cycles, if_valid held 1.
REQ-034 id_ready=0 with slot full, rvalid at pc=0x10 -> FULL, pcNext=0x14 once then holds; id_ready=1 -> if_pc=0x10 next cycle, then req at 0x14.
REQ-035 Request at 0x20 with 3-cycle latency, redirect to 0x100 in cycle 1 -> imem_addr stays 0x20 until rvalid, response discarded, next req at 0x100, no if_valid for 0x20.
REQ-036 redirect_pc=0x102 -> if_valid=1, if_misaligned=1, if_instr=0x13, if_pc=0x102, imem_req=0 until redirect to 0x200.
REQ-037 reset=0 mid-FULL -> all outputs at REQ-031 values within the same cycle, pcNext=RESET_VECTOR, skid contents lost.
